interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Sequences external interrupts INT0/INT1 into the processor core: synchronises and edge-detects inputs, latches pending requests, applies masking and priority, and presents a vector at instruction boundaries.
- Tracks in-service levels, the global interrupt-enable (IE) flag, and the IE save/restore around RETI.
- Sits between the pins and the core's fetch/commit sequencer; the core drives EI/DI/RETI strobes from decode and IRQ_ACK when it redirects fetch.

Parameters:
- VECTOR_BASE, 16'h0004, vector address for INT0.
- VECTOR_STRIDE, 4, byte distance between vectors; INT1 vector = VECTOR_BASE + VECTOR_STRIDE (16'h0008).

Ports:
- CLK  input  1  core clock, all state on rising edge
- RESET  input  1  asynchronous, active-high reset
- INT0  input  1  external non-maskable interrupt, asynchronous
- INT1  input  1  external maskable interrupt, asynchronous
- EI_EXEC  input  1  one-cycle strobe, EI instruction committed
- DI_EXEC  input  1  one-cycle strobe, DI instruction committed
- RETI_EXEC  input  1  one-cycle strobe, RETI committed
- IRQ_ACK  input  1  one-cycle strobe, core took the request at an instruction boundary
- IRQ_REQ  output  1  registered, request to core
- IRQ_VECTOR  output  16  registered, vector for the current request; valid while IRQ_REQ=1
- IE  output  1  global enable for INT1
- IN_SERVICE  output  2  bit0=INT0 in service, bit1=INT1 in service

Behaviour:
- Reset (async): PEND, IN_SERVICE, IE, IE_SAVE[1:0], sync/edge flops = 0; IRQ_REQ=0; IRQ_VECTOR=16'h0000.
- Input path: 2-flop synchroniser (see Optional Feature), then a rising-edge detector (1 flop). The edge pulse arrives 3 cycles after a pin rise with the synchroniser, 1 cycle without it.
- PEND0 is set on every INT0 edge regardless of IE.
- PEND1 is set on an INT1 edge only if IE=1 that cycle. Edges while IE=0 are discarded and are not remembered after a later EI.
- Eligibility:
  - INT0 is eligible if PEND0=1 and IN_SERVICE[0]=0. It may nest over INT1 service.
  - INT1 is eligible if PEND1=1, IE=1 and IN_SERVICE=0.
  - INT0 has priority over INT1.
- IRQ_REQ/IRQ_VECTOR are registered from eligibility one cycle later. The vector updates while unacknowledged, so INT0 may overtake a pending INT1. The core samples IRQ_VECTOR in the IRQ_ACK cycle.
- On IRQ_ACK with IRQ_REQ=1, for the source selected by the current IRQ_VECTOR:
  - clear its PEND;
  - set its IN_SERVICE bit;
  - IE_SAVE[src] <= IE;
  - IE <= 0.
  - Next cycle: IRQ_REQ=0, unless INT0 is now eligible over an INT1 in service.
  - IRQ_ACK with IRQ_REQ=0 is ignored.
- RETI_EXEC:
  - If IN_SERVICE[0]=1, clear it and restore IE <= IE_SAVE[0].
  - Else if IN_SERVICE[1]=1, clear it and restore IE <= IE_SAVE[1].
  - Else no-op.
- EI_EXEC sets IE=1; DI_EXEC clears IE. Both strobes in one cycle means DI wins.
- Simultaneous events:
  - IRQ_ACK with EI/DI: the ACK clear of IE wins.
  - RETI with a new edge: RETI applies first, and eligibility is evaluated on the updated state next cycle.
  - RETI with IRQ_ACK: ACK applies, then RETI clears the pre-existing in-service level.
- An INT0 edge while IN_SERVICE[0]=1 stays pending and fires after RETI. Its depth is 1: repeat edges merge.
- Reset mid-service: all state cleared immediately; IRQ_REQ drops asynchronously.

Optional Feature:
- INTC_SYNC_EN
  - Defined: 2-flop synchronisers on INT0/INT1 before the edge detector.
  - Undefined: pins feed the edge detector directly. This is for synchronous on-chip sources, saves 2 cycles latency and 4 flops; the edge pulse arrives 1 cycle after the pin rise.

Test Plan:
- Reset, IE=0, pulse INT0 -> IRQ_REQ=1 with IRQ_VECTOR=16'h0004 within 5 cycles (sync on). ACK -> IN_SERVICE=2'b01, IE=0. RETI -> IN_SERVICE=0, IE=0.
- IE=0, pulse INT1, then EI_EXEC -> IRQ_REQ stays 0 for 20 cycles; PEND1 never set.
- EI, pulse INT1 -> IRQ_VECTOR=16'h0008, IRQ_REQ=1. ACK -> IE=0, IN_SERVICE=2'b10. RETI -> IE=1, IN_SERVICE=0.
- INT1 in service (IE=0), pulse INT0 -> IRQ_REQ=1 with vector 16'h0004. ACK -> IN_SERVICE=2'b11. First RETI -> 2'b10, IE=0. Second RETI -> 2'b00, IE=1.
- IE=1, INT1 and INT0 edges in the same cycle -> vector 16'h0004 first. After ACK+RETI -> IRQ_REQ re-asserts with 16'h0008.
- EI_EXEC coincident with IRQ_ACK -> IE=0 next cycle. Assert RESET while IRQ_REQ=1 -> IRQ_REQ=0 and all outputs 0 before the next CLK edge.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Core-side bundle for the interrupt controller: pins, decode strobes, request/vector and status.
// master = core/pin side driving strobes, slave = the controller.
interface interrupt_controller_if;
   logic        int0;
   logic        int1;
   logic        ei_exec;
   logic        di_exec;
   logic        reti_exec;
   logic        irq_ack;
   logic        irq_req;
   logic [15:0] irq_vector;
   logic        ie;
   logic [1:0]  in_service;

   modport master (
      output int0, int1, ei_exec, di_exec, reti_exec, irq_ack,
      input  irq_req, irq_vector, ie, in_service
   );

   modport slave (
      input  int0, int1, ei_exec, di_exec, reti_exec, irq_ack,
      output irq_req, irq_vector, ie, in_service
   );
endinterface

// File: rtl/interrupt_controller.sv
// INT0/INT1 edge capture, masking, priority and IE save/restore feeding the core's fetch sequencer.
// Latency: pin rise to IRQ_REQ 4 cycles with INTC_SYNC_EN defined, 2 cycles without.
// No backpressure: a request is held until IRQ_ACK; ACK without a request is ignored.
module interrupt_controller #(
   parameter logic [15:0] VECTOR_BASE   = 16'h0004,
   parameter int          VECTOR_STRIDE = 4
) (
   input  logic            clk,
   input  logic            rst,
   interrupt_controller_if.slave bus
);

   localparam logic [15:0] VEC0 = VECTOR_BASE;
   localparam logic [15:0] VEC1 = VECTOR_BASE + 16'(VECTOR_STRIDE);

   logic [1:0]  pin_s;
   logic [1:0]  prev_q;
   logic [1:0]  edge_det;

   logic [1:0]  pend_q, pend_d;
   logic [1:0]  ins_q, ins_d;
   logic [1:0]  ie_save_q, ie_save_d;
   logic        ie_q, ie_d;
   logic        irq_req_q;
   logic [15:0] irq_vector_q;

   logic        ack_take;
   logic        ack_src;
   logic        elig0;
   logic        elig1;

`ifdef INTC_SYNC_EN
   logic [1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
      end else begin
         sync1_q <= {bus.int1, bus.int0};
         sync2_q <= sync1_q;
      end
   end

   assign pin_s = sync2_q;
`else
   assign pin_s = {bus.int1, bus.int0};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 2'b00;
      else     prev_q <= pin_s;
   end

   assign edge_det = pin_s & ~prev_q;

   // The granted source is identified by the vector the core sampled this cycle.
   assign ack_take = bus.irq_ack & irq_req_q;
   assign ack_src  = (irq_vector_q == VEC1);

   always_comb begin
      pend_d    = pend_q;
      ins_d     = ins_q;
      ie_d      = ie_q;
      ie_save_d = ie_save_q;

      if (bus.ei_exec) ie_d = 1'b1;
      if (bus.di_exec) ie_d = 1'b0;

      if (ack_take) begin
         pend_d[ack_src]    = 1'b0;
         ins_d[ack_src]     = 1'b1;
         ie_save_d[ack_src] = ie_q;
         ie_d               = 1'b0;
      end

      // RETI retires the level that was in service before any same-cycle ACK.
      if (bus.reti_exec) begin
         if (ins_q[0]) begin
            ins_d[0] = 1'b0;
            ie_d     = ie_save_q[0];
         end else if (ins_q[1]) begin
            ins_d[1] = 1'b0;
            ie_d     = ie_save_q[1];
         end
      end

      if (edge_det[0])         pend_d[0] = 1'b1;
      if (edge_det[1] && ie_q) pend_d[1] = 1'b1;
   end

   // Eligibility excludes whatever this cycle's ACK is consuming so REQ drops right after it.
   assign elig0 = pend_q[0] & ~ins_q[0] & ~(ack_take & ~ack_src);
   assign elig1 = pend_q[1] & ie_q & (ins_q == 2'b00) & ~ack_take;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q       <= 2'b00;
         ins_q        <= 2'b00;
         ie_save_q    <= 2'b00;
         ie_q         <= 1'b0;
         irq_req_q    <= 1'b0;
         irq_vector_q <= 16'h0000;
      end else begin
         pend_q    <= pend_d;
         ins_q     <= ins_d;
         ie_save_q <= ie_save_d;
         ie_q      <= ie_d;
         irq_req_q <= elig0 | elig1;
         if (elig0)      irq_vector_q <= VEC0;
         else if (elig1) irq_vector_q <= VEC1;
         else            irq_vector_q <= 16'h0000;
      end
   end

   assign bus.irq_req    = irq_req_q;
   assign bus.irq_vector = irq_vector_q;
   assign bus.ie         = ie_q;
   assign bus.in_service = ins_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed plan steps followed by random operations, each checked against a transaction-level model.
module tb_interrupt_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;

   interrupt_controller_if bus();

   interrupt_controller #(.VECTOR_BASE(16'h0004), .VECTOR_STRIDE(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Architectural state the spec describes, updated per completed operation.
   bit [1:0] m_pend;
   bit [1:0] m_ins;
   bit [1:0] m_save;
   bit       m_ie;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] m_vec();
      if (m_pend[0] && !m_ins[0])              return 16'h0004;
      if (m_pend[1] && m_ie && m_ins == 2'b00) return 16'h0008;
      return 16'h0000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      repeat (n) tick();
   endtask

   task automatic check_state(input string tag);
      logic [15:0] v;
      v = m_vec();
      check({tag, "_req"}, 16'(bus.irq_req), 16'(v != 16'h0000));
      check({tag, "_vec"}, bus.irq_vector, v);
      check({tag, "_ie"},  16'(bus.ie), 16'(m_ie));
      check({tag, "_ins"}, 16'(bus.in_service), 16'(m_ins));
   endtask

   task automatic pulse(input bit [1:0] m);
      bus.int0 = m[0];
      bus.int1 = m[1];
      tick();
      bus.int0 = 1'b0;
      bus.int1 = 1'b0;
      if (m[0]) m_pend[0] = 1'b1;
      if (m[1] && m_ie) m_pend[1] = 1'b1;
      settle(6);
   endtask

   task automatic strobe(input bit ei, input bit di, input bit reti, input bit ack);
      bit [1:0]    pre_ins;
      bit [1:0]    pre_save;
      bit          pre_ie;
      bit          nie;
      bit          s;
      logic [15:0] v;
      pre_ins  = m_ins;
      pre_save = m_save;
      pre_ie   = m_ie;
      v        = m_vec();
      nie      = pre_ie;
      if (ei) nie = 1'b1;
      if (di) nie = 1'b0;
      if (ack && v != 16'h0000) begin
         s         = (v == 16'h0008);
         m_pend[s] = 1'b0;
         m_ins[s]  = 1'b1;
         m_save[s] = pre_ie;
         nie       = 1'b0;
      end
      if (reti) begin
         if (pre_ins[0]) begin
            m_ins[0] = 1'b0;
            nie      = pre_save[0];
         end else if (pre_ins[1]) begin
            m_ins[1] = 1'b0;
            nie      = pre_save[1];
         end
      end
      m_ie = nie;
      bus.ei_exec   = ei;
      bus.di_exec   = di;
      bus.reti_exec = reti;
      bus.irq_ack   = ack;
      tick();
      bus.ei_exec   = 1'b0;
      bus.di_exec   = 1'b0;
      bus.reti_exec = 1'b0;
      bus.irq_ack   = 1'b0;
      settle(6);
   endtask

   initial begin
      int op;
      bus.int0      = 1'b0;
      bus.int1      = 1'b0;
      bus.ei_exec   = 1'b0;
      bus.di_exec   = 1'b0;
      bus.reti_exec = 1'b0;
      bus.irq_ack   = 1'b0;
      m_pend = 2'b00; m_ins = 2'b00; m_save = 2'b00; m_ie = 1'b0;
      rst = 1'b1;
      settle(2);
      check_state("reset");
      rst = 1'b0;
      tick();

      // INT0 is non-maskable: fires with IE=0, vector 0004.
      pulse(2'b01);
      check("int0_req", 16'(bus.irq_req), 16'h0001);
      check("int0_vec", bus.irq_vector, 16'h0004);
      strobe(0, 0, 0, 1);
      check("int0_ack_ins", 16'(bus.in_service), 16'h0001);
      check("int0_ack_ie", 16'(bus.ie), 16'h0000);
      strobe(0, 0, 1, 0);
      check_state("int0_reti");

      // INT1 edge while IE=0 must be forgotten.
      pulse(2'b10);
      strobe(1, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         check("masked_int1_quiet", 16'(bus.irq_req), 16'h0000);
         tick();
      end
      check_state("masked_int1");

      // Enabled INT1 and IE save/restore.
      pulse(2'b10);
      check("int1_vec", bus.irq_vector, 16'h0008);
      strobe(0, 0, 0, 1);
      check("int1_ack_ins", 16'(bus.in_service), 16'h0002);
      check("int1_ack_ie", 16'(bus.ie), 16'h0000);
      strobe(0, 0, 1, 0);
      check("int1_reti_ie", 16'(bus.ie), 16'h0001);
      check_state("int1_reti");

      // INT0 nests over INT1 service.
      pulse(2'b10);
      strobe(0, 0, 0, 1);
      pulse(2'b01);
      check("nest_vec", bus.irq_vector, 16'h0004);
      strobe(0, 0, 0, 1);
      check("nest_ins", 16'(bus.in_service), 16'h0003);
      strobe(0, 0, 1, 0);
      check("nest_reti1_ins", 16'(bus.in_service), 16'h0002);
      check("nest_reti1_ie", 16'(bus.ie), 16'h0000);
      strobe(0, 0, 1, 0);
      check("nest_reti2_ins", 16'(bus.in_service), 16'h0000);
      check("nest_reti2_ie", 16'(bus.ie), 16'h0001);

      // Simultaneous edges: INT0 first, INT1 after it retires.
      pulse(2'b11);
      check("both_vec0", bus.irq_vector, 16'h0004);
      strobe(0, 0, 0, 1);
      strobe(0, 0, 1, 0);
      check("both_req1", 16'(bus.irq_req), 16'h0001);
      check("both_vec1", bus.irq_vector, 16'h0008);
      strobe(0, 0, 0, 1);
      strobe(0, 0, 1, 0);
      check_state("both_done");

      // EI coincident with ACK leaves IE clear.
      pulse(2'b01);
      strobe(1, 0, 0, 1);
      check("ei_ack_ie", 16'(bus.ie), 16'h0000);
      check_state("ei_ack");
      strobe(0, 0, 1, 0);

      // Async reset while a request is up.
      pulse(2'b01);
      check("pre_reset_req", 16'(bus.irq_req), 16'h0001);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_req", 16'(bus.irq_req), 16'h0000);
      check("async_rst_vec", bus.irq_vector, 16'h0000);
      check("async_rst_ie", 16'(bus.ie), 16'h0000);
      check("async_rst_ins", 16'(bus.in_service), 16'h0000);
      m_pend = 2'b00; m_ins = 2'b00; m_save = 2'b00; m_ie = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check_state("after_reset");

      // Random operation mix.
      for (int n = 0; n < 200; n++) begin
         op = $urandom_range(0, 8);
         case (op)
            0: pulse(2'b01);
            1: pulse(2'b10);
            2: pulse(2'b11);
            3: strobe(1, 0, 0, 0);
            4: strobe(0, 1, 0, 0);
            5: strobe(0, 0, 1, 0);
            6: begin
               check("rnd_ack_vec", bus.irq_vector, m_vec());
               strobe(0, 0, 0, 1);
            end
            7: strobe(1, 1, 0, 0);
            default: strobe(1, 0, 0, 1);
         endcase
         check_state("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
